// File: rtl/ysyx_22040632_mem_arbiter.sv
`timescale 1ns/1ps
// Two-master (icache/dcache) to single AXI-master arbiter with round-robin tie
// break, mandatory IDLE turnaround between grants and response routing to the owner.
module ysyx_22040632_mem_arbiter #(
   parameter int DW = 64,
   parameter int AW = 32
) (
   input  logic              clk,
   input  logic              rrst_n,

   input  logic              i_rw_valid,
   output logic              i_rw_ready,
   input  logic [AW-1:0]     i_rw_addr,
   input  logic [7:0]        i_rw_len,
   input  logic [2:0]        i_rw_size,
   output logic              i_r_hs,
   output logic              i_r_last,
   output logic [DW-1:0]     i_data_read,

   input  logic              d_rw_valid,
   output logic              d_rw_ready,
   input  logic              d_rw_req,
   input  logic [AW-1:0]     d_rw_addr,
   input  logic [7:0]        d_rw_len,
   input  logic [2:0]        d_rw_size,
   input  logic [DW-1:0]     d_data_write,
   input  logic [DW/8-1:0]   d_wstrb,
   output logic              d_r_hs,
   output logic              d_r_last,
   output logic [DW-1:0]     d_data_read,

   output logic              m_rw_valid,
   output logic              m_rw_req,
   output logic [AW-1:0]     m_rw_addr,
   output logic [7:0]        m_rw_len,
   output logic [2:0]        m_rw_size,
   output logic [DW-1:0]     m_data_write,
   output logic [DW/8-1:0]   m_wstrb,
   input  logic              m_rw_ready,
   input  logic              m_r_hs,
   input  logic              m_r_last,
   input  logic [DW-1:0]     m_data_read,

   output logic [15:0]       dbg_gnt_cycles
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_e;

   localparam logic LG_I = 1'b0;
   localparam logic LG_D = 1'b1;

   state_e      state_q, state_d;
   logic        last_gnt_q, last_gnt_d;
   logic [15:0] cnt_q, cnt_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q    <= IDLE;
         last_gnt_q <= LG_I;
         cnt_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         cnt_q      <= cnt_d;
      end
   end

   // Grants leave only through IDLE, so every transaction is followed by a turnaround cycle.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (i_rw_valid && d_rw_valid)
               state_d = (last_gnt_q == LG_I) ? GNT_D : GNT_I;
            else if (i_rw_valid)
               state_d = GNT_I;
            else if (d_rw_valid)
               state_d = GNT_D;
            if (state_d != IDLE)
               cnt_d = 16'd0;
         end
         GNT_I: begin
            cnt_d = sat_inc(cnt_q);
            if (m_rw_ready) begin
               state_d    = IDLE;
               last_gnt_d = LG_I;
            end
         end
         GNT_D: begin
            cnt_d = sat_inc(cnt_q);
            if (m_rw_ready) begin
               state_d    = IDLE;
               last_gnt_d = LG_D;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request mux toward the master and response demux toward the owner; IDLE drives all zeros.
   always_comb begin
      m_rw_valid   = 1'b0;
      m_rw_req     = 1'b0;
      m_rw_addr    = '0;
      m_rw_len     = '0;
      m_rw_size    = '0;
      m_data_write = '0;
      m_wstrb      = '0;
      i_rw_ready   = 1'b0;
      i_r_hs       = 1'b0;
      i_r_last     = 1'b0;
      i_data_read  = '0;
      d_rw_ready   = 1'b0;
      d_r_hs       = 1'b0;
      d_r_last     = 1'b0;
      d_data_read  = '0;
      unique case (state_q)
         GNT_I: begin
            m_rw_valid  = i_rw_valid;
            m_rw_addr   = i_rw_addr;
            m_rw_len    = i_rw_len;
            m_rw_size   = i_rw_size;
            i_rw_ready  = m_rw_ready;
            i_r_hs      = m_r_hs;
            i_r_last    = m_r_last;
            i_data_read = m_data_read;
         end
         GNT_D: begin
            m_rw_valid   = d_rw_valid;
            m_rw_req     = d_rw_req;
            m_rw_addr    = d_rw_addr;
            m_rw_len     = d_rw_len;
            m_rw_size    = d_rw_size;
            m_data_write = d_data_write;
            m_wstrb      = d_wstrb;
            d_rw_ready   = m_rw_ready;
            d_r_hs       = m_r_hs;
            d_r_last     = m_r_last;
            d_data_read  = m_data_read;
         end
         default: ;
      endcase
   end

   assign dbg_gnt_cycles = cnt_q;

endmodule

// File: tb/tb_ysyx_22040632_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for the icache/dcache memory arbiter: directed scenarios plus random
// traffic, all checked cycle by cycle against a transaction-level owner model.
module tb_ysyx_22040632_mem_arbiter;
   localparam int DW = 64;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rrst_n = 1'b0;
   always #5 clk = ~clk;

   logic            i_rw_valid, i_rw_ready, i_r_hs, i_r_last;
   logic [AW-1:0]   i_rw_addr;
   logic [7:0]      i_rw_len;
   logic [2:0]      i_rw_size;
   logic [DW-1:0]   i_data_read;
   logic            d_rw_valid, d_rw_ready, d_rw_req, d_r_hs, d_r_last;
   logic [AW-1:0]   d_rw_addr;
   logic [7:0]      d_rw_len;
   logic [2:0]      d_rw_size;
   logic [DW-1:0]   d_data_write, d_data_read;
   logic [DW/8-1:0] d_wstrb;
   logic            m_rw_valid, m_rw_req, m_rw_ready, m_r_hs, m_r_last;
   logic [AW-1:0]   m_rw_addr;
   logic [7:0]      m_rw_len;
   logic [2:0]      m_rw_size;
   logic [DW-1:0]   m_data_write, m_data_read;
   logic [DW/8-1:0] m_wstrb;
   logic [15:0]     dbg_gnt_cycles;

   ysyx_22040632_mem_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rrst_n(rrst_n),
      .i_rw_valid(i_rw_valid), .i_rw_ready(i_rw_ready), .i_rw_addr(i_rw_addr),
      .i_rw_len(i_rw_len), .i_rw_size(i_rw_size), .i_r_hs(i_r_hs),
      .i_r_last(i_r_last), .i_data_read(i_data_read),
      .d_rw_valid(d_rw_valid), .d_rw_ready(d_rw_ready), .d_rw_req(d_rw_req),
      .d_rw_addr(d_rw_addr), .d_rw_len(d_rw_len), .d_rw_size(d_rw_size),
      .d_data_write(d_data_write), .d_wstrb(d_wstrb), .d_r_hs(d_r_hs),
      .d_r_last(d_r_last), .d_data_read(d_data_read),
      .m_rw_valid(m_rw_valid), .m_rw_req(m_rw_req), .m_rw_addr(m_rw_addr),
      .m_rw_len(m_rw_len), .m_rw_size(m_rw_size), .m_data_write(m_data_write),
      .m_wstrb(m_wstrb), .m_rw_ready(m_rw_ready), .m_r_hs(m_r_hs),
      .m_r_last(m_r_last), .m_data_read(m_data_read),
      .dbg_gnt_cycles(dbg_gnt_cycles)
   );

   int n_chk = 0;
   int n_bad = 0;

   // Reference model: owner 0=none, 1=icache, 2=dcache; last_srv is who finished last.
   int          owner = 0;
   int          last_srv = 1;
   int unsigned mcnt = 0;
   int          grants[$];
   bit          i_done, d_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit oi, od;
      oi = (owner == 1);
      od = (owner == 2);
      chk("m_rw_valid", 64'(m_rw_valid), 64'(oi ? i_rw_valid : (od ? d_rw_valid : 1'b0)));
      chk("m_rw_req", 64'(m_rw_req), 64'(od ? d_rw_req : 1'b0));
      chk("m_rw_addr", 64'(m_rw_addr), 64'(oi ? i_rw_addr : (od ? d_rw_addr : 32'd0)));
      chk("m_rw_len", 64'(m_rw_len), 64'(oi ? i_rw_len : (od ? d_rw_len : 8'd0)));
      chk("m_rw_size", 64'(m_rw_size), 64'(oi ? i_rw_size : (od ? d_rw_size : 3'd0)));
      chk("m_data_write", m_data_write, od ? d_data_write : 64'd0);
      chk("m_wstrb", 64'(m_wstrb), 64'(od ? d_wstrb : 8'd0));
      chk("i_rw_ready", 64'(i_rw_ready), 64'(oi && m_rw_ready));
      chk("i_r_hs", 64'(i_r_hs), 64'(oi && m_r_hs));
      chk("i_r_last", 64'(i_r_last), 64'(oi && m_r_last));
      chk("i_data_read", i_data_read, oi ? m_data_read : 64'd0);
      chk("d_rw_ready", 64'(d_rw_ready), 64'(od && m_rw_ready));
      chk("d_r_hs", 64'(d_r_hs), 64'(od && m_r_hs));
      chk("d_r_last", 64'(d_r_last), 64'(od && m_r_last));
      chk("d_data_read", d_data_read, od ? m_data_read : 64'd0);
      chk("dbg_cnt", 64'(dbg_gnt_cycles), 64'(mcnt));
   endtask

   task automatic model_step();
      i_done = 1'b0;
      d_done = 1'b0;
      if (owner == 0) begin
         if (i_rw_valid && d_rw_valid) owner = 3 - last_srv;
         else if (i_rw_valid)          owner = 1;
         else if (d_rw_valid)          owner = 2;
         if (owner != 0) begin
            mcnt = 0;
            grants.push_back(owner);
         end
      end else begin
         if (mcnt < 65535) mcnt++;
         if (m_rw_ready) begin
            if (owner == 1) i_done = 1'b1;
            else            d_done = 1'b1;
            last_srv = owner;
            owner    = 0;
         end
      end
   endtask

   // Inputs are changed only right after a rising edge; outputs are checked on the falling edge.
   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rrst_n = 1'b0;
      #1;
      chk("rst_m_rw_valid", 64'(m_rw_valid), 64'd0);
      chk("rst_i_rw_ready", 64'(i_rw_ready), 64'd0);
      chk("rst_d_rw_ready", 64'(d_rw_ready), 64'd0);
      chk("rst_i_r_hs", 64'(i_r_hs), 64'd0);
      chk("rst_d_r_hs", 64'(d_r_hs), 64'd0);
      chk("rst_i_r_last", 64'(i_r_last), 64'd0);
      chk("rst_d_r_last", 64'(d_r_last), 64'd0);
      chk("rst_dbg_cnt", 64'(dbg_gnt_cycles), 64'd0);
      owner    = 0;
      last_srv = 1;
      mcnt     = 0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rrst_n = 1'b1;
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      i_rw_valid = 0; i_rw_addr = '0; i_rw_len = '0; i_rw_size = '0;
      d_rw_valid = 0; d_rw_req = 0; d_rw_addr = '0; d_rw_len = '0; d_rw_size = '0;
      d_data_write = '0; d_wstrb = '0;
      m_rw_ready = 0; m_r_hs = 0; m_r_last = 0; m_data_read = '0;
   endtask

   task automatic finish_txn();
      m_r_hs = 0; m_r_last = 0; m_rw_ready = 1;
      tick();
      m_rw_ready = 0;
   endtask

   int gbase;
   int exp_order[4] = '{2, 1, 2, 1};

   initial begin
      idle_inputs();
      repeat (2) @(posedge clk);
      pulse_reset();

      // icache 8-beat burst
      i_rw_valid = 1; i_rw_addr = 32'h8000_0040; i_rw_len = 8'd7; i_rw_size = 3'd3;
      tick();
      chk("t1_grant", 64'(grants[$]), 64'd1);
      for (int b = 0; b < 8; b++) begin
         m_r_hs = 1; m_r_last = (b == 7); m_data_read = {$urandom, $urandom};
         tick();
      end
      finish_txn();
      i_rw_valid = 0;
      tick();
      chk("t1_idle_after", 64'(owner), 64'd0);

      // Both held valid for four transactions: D, I, D, I
      pulse_reset();
      gbase = grants.size();
      i_rw_valid = 1; i_rw_addr = 32'h8000_0100; i_rw_len = 8'd1; i_rw_size = 3'd3;
      d_rw_valid = 1; d_rw_req = 0; d_rw_addr = 32'h8000_2000; d_rw_len = 8'd0; d_rw_size = 3'd2;
      for (int t = 0; t < 4; t++) begin
         tick();
         m_r_hs = 1; m_r_last = 1; m_data_read = {$urandom, $urandom};
         tick();
         finish_txn();
      end
      chk("t2_count", 64'(grants.size() - gbase), 64'd4);
      for (int k = 0; k < 4; k++)
         if (gbase + k < grants.size())
            chk($sformatf("t2_order%0d", k), 64'(grants[gbase + k]), 64'(exp_order[k]));
      idle_inputs();
      tick();

      // dcache write with read strobes active throughout
      d_rw_valid = 1; d_rw_req = 1; d_rw_addr = 32'h8000_1000; d_rw_len = 8'd3; d_rw_size = 3'd3;
      d_wstrb = 8'hFF; d_data_write = {$urandom, $urandom};
      m_r_hs = 1;
      for (int c = 0; c < 5; c++) tick();
      chk("t3_req", 64'(m_rw_req), 64'd1);
      chk("t3_wstrb", 64'(m_wstrb), 64'hFF);
      chk("t3_i_r_hs", 64'(i_r_hs), 64'd0);
      finish_txn();
      idle_inputs();
      tick();

      // Owner drops valid early; grant must persist until m_rw_ready
      i_rw_valid = 1; i_rw_addr = 32'h8000_0200; i_rw_len = 8'd3; i_rw_size = 3'd3;
      tick();
      i_rw_valid = 0; d_rw_valid = 1; d_rw_addr = 32'h8000_3000;
      tick();
      tick();
      chk("t4_hold_owner", 64'(d_r_hs | d_rw_ready), 64'd0);
      finish_txn();
      tick();
      chk("t4_next_grant", 64'(grants[$]), 64'd2);
      finish_txn();
      idle_inputs();
      tick();

      // Reset during icache beat 3 with dcache pending
      i_rw_valid = 1; i_rw_addr = 32'h8000_0040; i_rw_len = 8'd7; i_rw_size = 3'd3;
      tick();
      d_rw_valid = 1; d_rw_req = 0; d_rw_addr = 32'h8000_4000;
      for (int b = 0; b < 3; b++) begin
         m_r_hs = 1; m_data_read = {$urandom, $urandom};
         tick();
      end
      pulse_reset();
      chk("t5_grant_after_rst", 64'(grants[$]), 64'd2);
      tick();
      finish_txn();
      idle_inputs();
      tick();

      // Spurious completion and beats while IDLE
      gbase = grants.size();
      m_rw_ready = 1; m_r_hs = 1; m_r_last = 1; m_data_read = {$urandom, $urandom};
      for (int c = 0; c < 3; c++) tick();
      chk("t6_no_grant", 64'(grants.size() - gbase), 64'd0);
      idle_inputs();
      tick();

      // Random traffic with occasional asynchronous resets
      for (int c = 0; c < 2000; c++) begin
         if (i_done || !i_rw_valid) begin
            i_rw_valid = ($urandom_range(2) != 0);
            i_rw_addr  = $urandom;
            i_rw_len   = 8'($urandom_range(15));
            i_rw_size  = 3'($urandom_range(3));
         end
         if (d_done || !d_rw_valid) begin
            d_rw_valid   = ($urandom_range(2) != 0);
            d_rw_req     = 1'($urandom_range(1));
            d_rw_addr    = $urandom;
            d_rw_len     = 8'($urandom_range(15));
            d_rw_size    = 3'($urandom_range(3));
            d_data_write = {$urandom, $urandom};
            d_wstrb      = 8'($urandom);
         end
         m_rw_ready  = ($urandom_range(5) == 0);
         m_r_hs      = 1'($urandom_range(1));
         m_r_last    = 1'($urandom_range(1));
         m_data_read = {$urandom, $urandom};
         if ($urandom_range(199) == 0) pulse_reset();
         else                          tick();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
